// File: rtl/pim_mac_sequencer.sv
// CFU command sequencer for a bit-serial processing-in-memory MAC macro.
// Handles row READ/WRITE and IBITS-pass MAC with a held, overflow-tracked accumulator.
module pim_mac_sequencer #(
  parameter int DWIDTH = 32,
  parameter int ROWS   = 8,
  parameter int IBITS  = 8,
  localparam int AW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int BW    = (IBITS > 1) ? $clog2(IBITS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_payload_function_id,
  input  logic [DWIDTH-1:0] cmd_payload_inputs_0,
  input  logic [DWIDTH-1:0] cmd_payload_inputs_1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_payload_response_ok,
  output logic [DWIDTH-1:0] rsp_payload_outputs_0,
  output logic [AW-1:0]     mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              pim_en,
  output logic [ROWS-1:0]   pim_rwl,
  input  logic [DWIDTH-1:0] pim_psum,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_MEM, S_RDWAIT, S_MAC, S_DRAIN, S_RESP} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_MAC, OP_MAC_ACC} op_t;

  state_t                      state;
  op_t                         op_q;
  logic [ROWS*IBITS-1:0]       act_q;
  logic [DWIDTH-1:0]           data_q;
  logic [DWIDTH-1:0]           acc;
  logic                        ovf;
  logic [BW-1:0]               bidx;
  logic                        add_vld;
  logic [BW-1:0]               add_sh;

  op_t                         cmd_op;
  logic [2*DWIDTH-1:0]         cmd_ops;
  logic [ROWS-1:0][IBITS-1:0]  rwl_src;
  logic [BW-1:0]               rwl_b;
  logic [ROWS-1:0]             rwl_nxt;
  logic [DWIDTH+IBITS-1:0]     term_ext;
  logic [DWIDTH:0]             sum;
  logic                        ovf_term;
  logic                        unused_ok;

  assign cmd_op    = op_t'(cmd_payload_function_id[1:0]);
  assign cmd_ops   = {cmd_payload_inputs_1, cmd_payload_inputs_0};
  assign unused_ok = ^cmd_payload_function_id[9:2+AW];

  // Wordline pattern for the next issue: bit 0 straight from the payload at
  // accept, later bits from the registered activations.
  always_comb begin
    rwl_src = (state == S_IDLE) ? cmd_ops[ROWS*IBITS-1:0] : act_q;
    rwl_b   = (state == S_IDLE) ? '0 : bidx + 1'b1;
    rwl_nxt = '0;
    for (int r = 0; r < ROWS; r++) rwl_nxt[r] = rwl_src[r][rwl_b];
  end

  // Partial sum weighted by its bit position; any bit lost to the shift or
  // the add marks the result as overflowed.
  always_comb begin
    term_ext = {{IBITS{1'b0}}, pim_psum} << add_sh;
    sum      = {1'b0, acc} + {1'b0, term_ext[DWIDTH-1:0]};
    ovf_term = (term_ext[DWIDTH+IBITS-1:DWIDTH] != '0) | sum[DWIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                   <= S_IDLE;
      op_q                    <= OP_READ;
      act_q                   <= '0;
      data_q                  <= '0;
      acc                     <= '0;
      ovf                     <= 1'b0;
      bidx                    <= '0;
      add_vld                 <= 1'b0;
      add_sh                  <= '0;
      cmd_ready               <= 1'b1;
      rsp_valid               <= 1'b0;
      rsp_payload_response_ok <= 1'b0;
      rsp_payload_outputs_0   <= '0;
      mem_addr                <= '0;
      mem_wdata               <= '0;
      mem_we                  <= 1'b0;
      mem_re                  <= 1'b0;
      pim_en                  <= 1'b0;
      pim_rwl                 <= '0;
      busy                    <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      mem_re  <= 1'b0;
      pim_en  <= 1'b0;
      pim_rwl <= '0;
      add_vld <= pim_en;
      add_sh  <= bidx;
      if (add_vld) begin
        acc <= sum[DWIDTH-1:0];
        ovf <= ovf | ovf_term;
      end
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            act_q     <= cmd_ops[ROWS*IBITS-1:0];
            data_q    <= cmd_payload_inputs_0;
            mem_addr  <= cmd_payload_function_id[2+AW-1:2];
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            case (cmd_op)
              OP_READ: begin
                state  <= S_MEM;
                mem_re <= 1'b1;
              end
              OP_WRITE: begin
                state     <= S_MEM;
                mem_we    <= 1'b1;
                mem_wdata <= cmd_payload_inputs_0;
              end
              default: begin
                if (cmd_op == OP_MAC) begin
                  acc <= '0;
                  ovf <= 1'b0;
                end
                state   <= S_MAC;
                bidx    <= '0;
                pim_en  <= 1'b1;
                pim_rwl <= rwl_nxt;
              end
            endcase
          end
        end
        S_MEM: begin
          if (op_q == OP_WRITE) begin
            state                   <= S_RESP;
            rsp_valid               <= 1'b1;
            rsp_payload_outputs_0   <= data_q;
            rsp_payload_response_ok <= 1'b1;
          end else begin
            state <= S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          state                   <= S_RESP;
          rsp_valid               <= 1'b1;
          rsp_payload_outputs_0   <= mem_rdata;
          rsp_payload_response_ok <= 1'b1;
        end
        S_MAC: begin
          if (bidx == BW'(IBITS - 1)) begin
            state <= S_DRAIN;
          end else begin
            bidx    <= bidx + 1'b1;
            pim_en  <= 1'b1;
            pim_rwl <= rwl_nxt;
          end
        end
        S_DRAIN: begin
          // The last partial sum lands now; respond with the post-add value.
          state                   <= S_RESP;
          rsp_valid               <= 1'b1;
          rsp_payload_outputs_0   <= sum[DWIDTH-1:0];
          rsp_payload_response_ok <= ~(ovf | ovf_term);
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pim_mac_sequencer.md
PIM_MAC_SEQUENCER -- requirements
Module: pim_mac_sequencer

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, meaning data, weight-row, partial-sum and result width.
REQ-002 SHALL have parameter ROWS, default 8, meaning PIM rows (wordlines); ROWS*IBITS SHALL equal 64.
REQ-003 SHALL have parameter IBITS, default 8, meaning activation precision (bit-serial passes per MAC).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_payload_function_id in 10, cmd_payload_inputs_0 in DWIDTH, cmd_payload_inputs_1 in DWIDTH, meaning the CFU command channel.
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_payload_response_ok out 1, rsp_payload_outputs_0 out DWIDTH, meaning the CFU response channel.
REQ-008 SHALL have ports mem_addr out log2(ROWS), mem_wdata out DWIDTH, mem_we out 1, mem_re out 1, mem_rdata in DWIDTH, meaning macro row access; mem_rdata is valid one cycle after mem_re.
REQ-009 SHALL have ports pim_en out 1, pim_rwl out ROWS, pim_psum in DWIDTH, meaning the macro compute interface; pim_psum is valid one cycle after a pim_en cycle and equals the unsigned sum of the weight rows selected by pim_rwl.
REQ-010 SHALL have port busy  out  1  meaning the state is not IDLE.

Function
REQ-011 SHALL decode function_id[1:0] as 00 READ, 01 WRITE, 10 MAC (clear then accumulate), 11 MAC_ACC (accumulate onto the held accumulator); the row address SHALL be function_id[2+log2(ROWS)-1:2]; other bits are ignored.
REQ-012 SHALL assert cmd_ready only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready, and all payload fields SHALL be registered at that edge.
REQ-013 SHALL implement FSM states IDLE, MEM, RDWAIT, MAC, DRAIN and RESP.
REQ-014 FSM transitions: IDLE->MEM on accepted READ or WRITE; IDLE->MAC on accepted MAC or MAC_ACC; MEM->RDWAIT for READ; MEM->RESP for WRITE; RDWAIT->RESP; MAC->DRAIN after IBITS cycles; DRAIN->RESP; RESP->IDLE on rsp_ready.
REQ-015 WRITE: in MEM, SHALL drive mem_we=1 for exactly one cycle with the registered address and mem_wdata=inputs_0; the response data SHALL be inputs_0.
REQ-016 READ: in MEM, SHALL drive mem_re=1 for exactly one cycle; in RDWAIT, SHALL capture mem_rdata as the response data.
REQ-017 MAC: activation for row r is bits [8r+7:8r] of {inputs_1,inputs_0}; in MAC cycle b (b=0..IBITS-1), SHALL drive pim_en=1 and pim_rwl[r]=bit b of activation r.
REQ-018 SHALL update acc <= acc + (pim_psum << b) one cycle after issue b, so the final add occurs in DRAIN; acc is DWIDTH bits and wraps modulo 2^DWIDTH.
REQ-019 MAC SHALL clear acc and the overflow flag at accept; MAC_ACC SHALL retain both; READ and WRITE SHALL leave acc untouched.
REQ-020 SHALL set a sticky overflow flag on any carry-out or shifted-out nonzero bit; rsp_payload_response_ok SHALL be the inverse of the flag for MAC ops and 1 for READ and WRITE.
REQ-021 Latency from the accept edge to rsp_valid: WRITE 2 cycles, READ 3 cycles, MAC IBITS+2 cycles (10 at default).
REQ-022 In RESP, rsp_valid=1 with data and ok stable until rsp_ready; a new command SHALL be accepted no earlier than the cycle after the handshake.
REQ-023 mem_we, mem_re and pim_en SHALL be 0 outside their specified states; pim_rwl SHALL be 0 when pim_en=0.

Reset
REQ-024 On reset low, SHALL immediately enter IDLE and drive all outputs to 0 except cmd_ready=1; acc and the overflow flag SHALL be cleared.
REQ-025 Reset asserted mid-operation SHALL abort it with no response; the first command after release SHALL behave as from power-up.

Verification
REQ-026 WRITE row 3 with 0x000000A5, then READ row 3 -> one mem_we pulse at addr 3; READ response 0x000000A5, ok=1, rsp_valid 3 cycles after accept.
REQ-027 Rows 0..7 hold 1..8; MAC with inputs_0=inputs_1=0x01010101 -> pim_rwl=0xFF for b=0 and 0x00 for b=1..7; result 36, ok=1, rsp_valid 10 cycles after accept.
REQ-028 MAC_ACC with the same operands after REQ-027 -> result 72, ok=1.
REQ-029 Row 0 = 0xFFFFFFFF, activation 0xFF on row 0 only -> wrapped result 0xFFFFFF01, ok=0.
REQ-030 rsp_ready low for 5 cycles in RESP -> rsp_valid, data and ok held; cmd_ready=0 and busy=1 throughout.
REQ-031 reset low during MAC cycle b=4 -> outputs 0 and cmd_ready=1 immediately, no rsp_valid; a subsequent MAC returns the correct value.
